butterfly_s2p: RTL
==================

BUTTERFLY_S2P -- requirements
Module: butterfly_s2p

Interface
REQ-001 SHALL have parameter data_width, default 16: width of one serial word.
REQ-002 SHALL have parameter num_output, default 8: words per parallel frame; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port by_pass  input  1  1 = parallel pass-through mode, 0 = serial-to-parallel mode.
REQ-006 SHALL have port up_serial_dat  input  data_width  incoming serial word.
REQ-007 SHALL have port up_serial_vld  input  1  serial word valid.
REQ-008 SHALL have port up_serial_rdy  output  1  serial word accepted when vld & rdy.
REQ-009 SHALL have port up_parallel_dat  input  num_output*data_width  bypass frame.
REQ-010 SHALL have port up_parallel_vld  input  1  bypass frame valid.
REQ-011 SHALL have port up_parallel_rdy  output  1  bypass frame ready.
REQ-012 SHALL have port dn_dat  output  num_output*data_width  assembled frame; slot i at bits [data_width*i +: data_width].
REQ-013 SHALL have port dn_vld  output  1  frame valid.
REQ-014 SHALL have port dn_rdy  input  1  downstream ready; transfer when dn_vld & dn_rdy.

Function
REQ-015 SHALL keep 32-bit word counter wcnt, incremented by 1 on each accepted serial word, wrapping 0xFFFFFFFF->0; L = log2(num_output).
REQ-016 SHALL write each accepted word into slot = (wcnt[L-1:0] + popcount(wcnt[L+7:L])) mod num_output, using wcnt before increment.
REQ-017 SHALL use states FILL and FULL; FILL -> FULL on acceptance when wcnt[L-1:0] = num_output-1; FULL -> FILL on dn_vld & dn_rdy.
REQ-018 SHALL drive up_serial_rdy = 1 only in FILL with by_pass = 0; 0 in FULL (no overlap of drain and fill).
REQ-019 SHALL assert dn_vld (serial mode) in FULL, i.e. first cycle after the num_output-th word is accepted; latency 1 cycle.
REQ-020 SHALL hold dn_dat and dn_vld stable while dn_vld & !dn_rdy.
REQ-021 SHALL not clear slot registers between frames; every slot is overwritten once per frame.
REQ-022 SHALL, when by_pass = 1, drive dn_dat = up_parallel_dat, dn_vld = up_parallel_vld, up_parallel_rdy = dn_rdy combinationally; up_parallel_rdy = 0 when by_pass = 0.
REQ-023 SHALL, when by_pass rises mid-frame, freeze state, slots and wcnt; the serial frame resumes unchanged when by_pass falls.
REQ-024 SHALL ignore up_serial_dat when up_serial_vld = 0 or up_serial_rdy = 0.

Reset
REQ-025 SHALL on rst_n = 0 immediately set state = FILL, wcnt = 0, all slots = 0, dn_vld = 0 (serial mode), up_serial_rdy = 1 after release if by_pass = 0.
REQ-026 SHALL discard any partial frame on reset mid-operation; the next accepted word has wcnt = 0.

Configuration
REQ-027 SHALL, with macro BUTTERFLY_S2P_PERMUTE_EN defined, use the slot formula of REQ-016.
REQ-028 SHALL, without BUTTERFLY_S2P_PERMUTE_EN, use slot = wcnt[L-1:0] (linear order); all other behaviour identical.

Structure
REQ-029 SHALL place the state enumeration (FILL, FULL) and the popcount window width (8) in shared package butterfly_pkg.
REQ-030 SHALL implement the slot computation in one sub-module butterfly_slot_calc (wcnt in, slot out, purely combinational), reusable by the serializer.

Verification (num_output = 8, data_width = 16, PERMUTE_EN defined unless noted)
REQ-031 SHALL cover: reset, 8 words 0x0100..0x0107 back-to-back, dn_rdy = 1 -> dn_vld 1 cycle after 8th accept, slot k = 0x0100+k, up_serial_rdy = 0 for that cycle.
REQ-032 SHALL cover: second frame 0x0200..0x0207 -> slot0 = 0x0207, slot1 = 0x0200, slot k = 0x0200+(k-1) for k = 1..7.
REQ-033 SHALL cover: dn_rdy = 0 for 5 cycles after frame complete -> dn_dat/dn_vld stable, up_serial_rdy = 0, no word lost; drain then next frame accepted.
REQ-034 SHALL cover: by_pass = 1 after 3 words, parallel frame 0xA5A5 repeated passed to dn_dat same cycle; by_pass = 0, 5 more words -> frame completes with original 3 words intact.
REQ-035 SHALL cover: rst_n pulsed after 4 words -> dn_vld = 0, next 8 words form frame with slot k = word k; and PERMUTE_EN undefined, frame 2 -> slot k = 0x0200+k.

Source files
------------

// File: rtl/butterfly_pkg.sv
// Shared types and constants for the butterfly serial-to-parallel block.
// The permuted slot order is enabled by defining BUTTERFLY_S2P_PERMUTE_EN.
package butterfly_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } s2p_state_e;

  // Number of word-counter bits above the slot index that feed the rotation.
  localparam int POPCNT_WIN = 8;

  function automatic logic [3:0] popcount_win(input logic [POPCNT_WIN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < POPCNT_WIN; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/butterfly_slot_calc.sv
// Maps the running word count to a frame slot: linear by default, rotated by
// the popcount of the frame-number window when BUTTERFLY_S2P_PERMUTE_EN is defined.
module butterfly_slot_calc
  import butterfly_pkg::*;
#(
  parameter int num_output = 8
) (
  input  logic [31:0]                   wcnt,
  output logic [$clog2(num_output)-1:0] slot
);

  localparam int L = $clog2(num_output);

`ifdef BUTTERFLY_S2P_PERMUTE_EN
  logic [3:0]   ones;
  logic [L+3:0] sum;
  logic         unused_bits;

  // The mod num_output falls out of keeping only the low L bits of the sum.
  always_comb begin
    ones = popcount_win(wcnt[L +: POPCNT_WIN]);
    sum  = {4'b0000, wcnt[L-1:0]} + {{L{1'b0}}, ones};
    slot = sum[L-1:0];
  end

  assign unused_bits = ^{sum[L+3:L], wcnt[31:L+POPCNT_WIN]};
`else
  logic unused_bits;

  always_comb begin
    slot = wcnt[L-1:0];
  end

  assign unused_bits = ^wcnt[31:L];
`endif

endmodule

// File: rtl/butterfly_s2p.sv
// Serial-to-parallel frame assembler with a parallel bypass path.
// Slot ordering is linear unless BUTTERFLY_S2P_PERMUTE_EN is defined.
module butterfly_s2p
  import butterfly_pkg::*;
#(
  parameter int data_width = 16,
  parameter int num_output = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             by_pass,
  input  logic [data_width-1:0]            up_serial_dat,
  input  logic                             up_serial_vld,
  output logic                             up_serial_rdy,
  input  logic [num_output*data_width-1:0] up_parallel_dat,
  input  logic                             up_parallel_vld,
  output logic                             up_parallel_rdy,
  output logic [num_output*data_width-1:0] dn_dat,
  output logic                             dn_vld,
  input  logic                             dn_rdy,
  output s2p_state_e                       dbg_state
);

  // Handshakes: a word/frame moves on a rising clk edge where vld & rdy are
  // both high; a producer holding vld keeps its data stable until it moves.

  localparam int L = $clog2(num_output);
  localparam logic [L-1:0] LAST_IDX = L'(num_output - 1);

  s2p_state_e state_q, state_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [num_output-1:0][data_width-1:0] slots_q, slots_d;

  logic [L-1:0] wr_slot;
  logic         ser_rdy;
  logic         accept;
  logic         drain;

  butterfly_slot_calc #(
    .num_output(num_output)
  ) u_slot_calc (
    .wcnt(wcnt_q),
    .slot(wr_slot)
  );

  // While by_pass is high the serial side is frozen: no fill, no drain.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    slots_d = slots_q;
    ser_rdy = (state_q == FILL) && !by_pass;
    accept  = ser_rdy && up_serial_vld;
    drain   = (state_q == FULL) && !by_pass && dn_rdy;

    if (accept) begin
      slots_d[wr_slot] = up_serial_dat;
      wcnt_d           = wcnt_q + 32'd1;
      if (wcnt_q[L-1:0] == LAST_IDX) begin
        state_d = FULL;
      end
    end

    if (drain) begin
      state_d = FILL;
    end
  end

  always_comb begin
    up_serial_rdy   = ser_rdy;
    up_parallel_rdy = by_pass && dn_rdy;
    dn_vld          = by_pass ? up_parallel_vld : (state_q == FULL);
    dn_dat          = by_pass ? up_parallel_dat : slots_q;
    dbg_state       = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      wcnt_q  <= '0;
      slots_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      slots_q <= slots_d;
    end
  end

endmodule
